// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the LFSR period controller: FSM states,
// default tap mask and the Fibonacci next-state function.
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0] DEFAULT_TAPS_8 = 8'hB8;
  localparam int         MAX_WIDTH      = 16;

  // Callers zero-extend q and taps to MAX_WIDTH and slice the result back.
  function automatic logic [MAX_WIDTH-1:0] lfsr_next(
    input logic [MAX_WIDTH-1:0] q,
    input logic [MAX_WIDTH-1:0] taps,
    input int unsigned          width
  );
    logic [MAX_WIDTH-1:0] mask;
    mask = (MAX_WIDTH'(1) << width) - MAX_WIDTH'(1);
    return ((q << 1) & mask) | {{(MAX_WIDTH-1){1'b0}}, ^(q & taps)};
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// LFSR state register: load takes priority over a single step per cycle.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int                WIDTH = 8,
  parameter logic [WIDTH-1:0]  TAPS  = WIDTH'(DEFAULT_TAPS_8)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] step;

  assign step = WIDTH'(lfsr_next(MAX_WIDTH'(q), MAX_WIDTH'(TAPS), WIDTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= seed;
    end else if (en) begin
      q <= step;
    end
  end

endmodule

// File: rtl/lfsr_period_ctrl.sv
// Measures the period of an internal Fibonacci LFSR from a given seed.
// Build option: define LFSR_ZERO_DETECT_EN to end a run early on the all-zero lock-up state.
module lfsr_period_ctrl
  import lfsr_pkg::*;
#(
  parameter int                WIDTH = 8,
  parameter logic [WIDTH-1:0]  TAPS  = WIDTH'(DEFAULT_TAPS_8)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] period,
  output logic             maximal,
  output logic             timeout,
  output logic             seed_err,
  output logic [WIDTH-1:0] lfsr_q
);

  localparam logic [WIDTH:0] CNT_FULL = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0] CNT_MAX  = {1'b0, {WIDTH{1'b1}}};

  state_t           state;
  logic [WIDTH-1:0] seed_r;
  logic [WIDTH:0]   cnt;
  logic [WIDTH:0]   cnt_inc;
  logic [WIDTH-1:0] next_q;
  logic             match;
  logic             expired;

  assign cnt_inc = cnt + 1'b1;
  assign next_q  = WIDTH'(lfsr_next(MAX_WIDTH'(lfsr_q), MAX_WIDTH'(TAPS), WIDTH));
  assign match   = (next_q == seed_r);

`ifdef LFSR_ZERO_DETECT_EN
  assign expired = (cnt_inc == CNT_FULL) || (next_q == '0);
`else
  assign expired = (cnt_inc == CNT_FULL);
`endif

  assign busy = (state == LOAD) || (state == RUN);
  assign done = (state == DONE);

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .load  (state == LOAD),
    .en    (state == RUN),
    .seed  (seed_r),
    .q     (lfsr_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      seed_r   <= '0;
      cnt      <= '0;
      period   <= '0;
      maximal  <= 1'b0;
      timeout  <= 1'b0;
      seed_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // Flags are cleared on every accepted start so exactly one result flag is ever set.
            period   <= '0;
            maximal  <= 1'b0;
            timeout  <= 1'b0;
            if (seed != '0) begin
              seed_r   <= seed;
              seed_err <= 1'b0;
              state    <= LOAD;
            end else begin
              seed_err <= 1'b1;
              state    <= DONE;
            end
          end
        end
        LOAD: begin
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          cnt <= cnt_inc;
          if (match) begin
            period  <= cnt_inc[WIDTH-1:0];
            maximal <= (cnt_inc == CNT_MAX);
            state   <= DONE;
          end else if (expired) begin
            timeout <= 1'b1;
            period  <= '0;
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_period_ctrl.sv
// Bench for lfsr_period_ctrl: four instances (8-bit B8, 4-bit C/A/1) checked
// cycle by cycle against a walk-the-sequence model of the measurement.
module tb_lfsr_period_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_s = 1'b0;
  logic [7:0] seed_s = 8'h00;
  int         sel = 0;

  always #5 clk = ~clk;

  logic       busy8, done8, max8, tmo8, serr8;
  logic [7:0] per8, q8;

  lfsr_period_ctrl #(.WIDTH(8), .TAPS(8'hB8)) u8 (
    .clk(clk), .reset(reset), .start(start_s && sel == 0), .seed(seed_s),
    .busy(busy8), .done(done8), .period(per8), .maximal(max8),
    .timeout(tmo8), .seed_err(serr8), .lfsr_q(q8)
  );

  logic       busy4 [3];
  logic       done4 [3];
  logic       max4  [3];
  logic       tmo4  [3];
  logic       serr4 [3];
  logic [3:0] per4  [3];
  logic [3:0] q4    [3];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g4
      lfsr_period_ctrl #(
        .WIDTH(4),
        .TAPS(gi == 0 ? 4'hC : (gi == 1 ? 4'hA : 4'h1))
      ) u (
        .clk(clk), .reset(reset), .start(start_s && sel == gi + 1), .seed(seed_s[3:0]),
        .busy(busy4[gi]), .done(done4[gi]), .period(per4[gi]), .maximal(max4[gi]),
        .timeout(tmo4[gi]), .seed_err(serr4[gi]), .lfsr_q(q4[gi])
      );
    end
  endgenerate

  logic       obs_busy, obs_done, obs_max, obs_tmo, obs_serr;
  logic [7:0] obs_period, obs_q;

  always_comb begin
    obs_busy   = busy8;
    obs_done   = done8;
    obs_max    = max8;
    obs_tmo    = tmo8;
    obs_serr   = serr8;
    obs_period = per8;
    obs_q      = q8;
    if (sel != 0) begin
      obs_busy   = busy4[sel-1];
      obs_done   = done4[sel-1];
      obs_max    = max4[sel-1];
      obs_tmo    = tmo4[sel-1];
      obs_serr   = serr4[sel-1];
      obs_period = {4'b0000, per4[sel-1]};
      obs_q      = {4'b0000, q4[sel-1]};
    end
  end

  // Model: the whole expected run is precomputed at start time.
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit m_valid = 1'b0;
  int m_start, m_steps, m_period, m_prev_q;
  bit m_max, m_tmo, m_serr;
  int m_seq [0:256];
  int done_rel = -1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int width_of(input int s);
    return (s == 0) ? 8 : 4;
  endfunction

  function automatic int taps_of(input int s);
    case (s)
      0:       return 'hB8;
      1:       return 'hC;
      2:       return 'hA;
      default: return 'h1;
    endcase
  endfunction

  // Shift left within the width, feed back the parity of the tapped bits.
  function automatic int mstep(input int s, input int taps, input int w);
    return ((s * 2) % (1 << w)) + ($countones(s & taps) % 2);
  endfunction

  function automatic int exp_q();
    int rel;
    if (!m_valid) return 0;
    rel = cyc - m_start;
    if (m_serr || rel <= 0) return m_prev_q;
    return m_seq[(rel - 1 > m_steps) ? m_steps : rel - 1];
  endfunction

  task automatic model_start(input int seed);
    int w, taps, s;
    w          = width_of(sel);
    taps       = taps_of(sel);
    m_prev_q   = exp_q();
    m_start    = cyc + 1;
    m_valid    = 1'b1;
    m_serr     = (seed == 0);
    m_period   = 0;
    m_max      = 1'b0;
    m_tmo      = 1'b0;
    m_steps    = -1;
    m_seq[0]   = seed;
    if (!m_serr) begin
      s = seed;
      for (int k = 1; k <= (1 << w); k++) begin
        s = mstep(s, taps, w);
        m_seq[k] = s;
        if (s == seed) begin
          m_steps  = k;
          m_period = k;
          m_max    = (k == (1 << w) - 1);
          break;
        end
`ifdef LFSR_ZERO_DETECT_EN
        if (s == 0) begin
          m_steps = k;
          m_tmo   = 1'b1;
          break;
        end
`endif
        if (k == (1 << w)) begin
          m_steps = k;
          m_tmo   = 1'b1;
        end
      end
    end
  endtask

  task automatic check_cycle();
    int  rel;
    bit  fin;
    if (!m_valid) begin
      chk("busy", obs_busy, 0);
      chk("done", obs_done, 0);
      chk("period", obs_period, 0);
      chk("maximal", obs_max, 0);
      chk("timeout", obs_tmo, 0);
      chk("seed_err", obs_serr, 0);
      chk("lfsr_q", obs_q, 0);
    end else begin
      rel = cyc - m_start;
      fin = (rel >= m_steps + 1);
      chk("busy", obs_busy, int'(rel >= 0 && rel <= m_steps));
      chk("done", obs_done, int'(rel == m_steps + 1));
      chk("period", obs_period, fin ? m_period : 0);
      chk("maximal", obs_max, fin ? int'(m_max) : 0);
      chk("timeout", obs_tmo, fin ? int'(m_tmo) : 0);
      chk("seed_err", obs_serr, fin ? int'(m_serr) : 0);
      chk("lfsr_q", obs_q, exp_q());
      if (obs_done) done_rel = rel;
    end
  endtask

  always begin
    @(posedge clk);
    cyc++;
    #1;
    check_cycle();
  end

  task automatic do_reset(input int new_sel);
    @(negedge clk);
    reset   = 1'b0;
    sel     = new_sel;
    m_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", obs_busy, 0);
    chk("rst_q", obs_q, 0);
    reset = 1'b1;
  endtask

  task automatic launch(input int seed);
    @(negedge clk);
    model_start(seed);
    done_rel = -1;
    start_s  = 1'b1;
    seed_s   = seed[7:0];
    @(negedge clk);
    start_s = 1'b0;
  endtask

  // poke >= 0 pulses an extra start that must be ignored mid-run.
  task automatic measure(input int seed, input int poke);
    int lim;
    lim = (1 << width_of(sel)) + 8;
    launch(seed);
    for (int i = 0; i < lim && done_rel < 0; i++) begin
      start_s = (i == poke);
      seed_s  = (i == poke) ? 8'h01 : seed[7:0];
      @(negedge clk);
    end
    start_s = 1'b0;
    chk("done_seen", int'(done_rel >= 0), 1);
    repeat (2) @(negedge clk);
  endtask

  int exp_a [7] = '{1, 2, 5, 10, 4, 8, 1};

  initial begin
    do_reset(0);

    measure(0, -1);
    chk("serr_done_edge", done_rel, 0);
    chk("serr_flag", obs_serr, 1);
    chk("serr_period", obs_period, 0);

    measure('h32, 50);
    chk("p255_done_edge", done_rel, 256);
    chk("p255_period", obs_period, 255);
    chk("p255_maximal", obs_max, 1);
    chk("p255_timeout", obs_tmo, 0);

    launch('h32);
    for (int i = 0; i < 200 && (cyc - m_start) < 100; i++) @(negedge clk);
    do_reset(0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", done_rel, -1);
    measure('h32, -1);
    chk("rerun_period", obs_period, 255);

    do_reset(1);
    measure(1, -1);
    chk("c_done_edge", done_rel, 16);
    chk("c_period", obs_period, 15);
    chk("c_maximal", obs_max, 1);

    do_reset(2);
    measure(1, -1);
    for (int k = 0; k < 7; k++) chk("a_seq", m_seq[k], exp_a[k]);
    chk("a_period", obs_period, 6);
    chk("a_maximal", obs_max, 0);

    do_reset(3);
    measure(2, -1);
`ifdef LFSR_ZERO_DETECT_EN
    chk("lock_done_edge", done_rel, 4);
`else
    chk("lock_done_edge", done_rel, 17);
`endif
    chk("lock_timeout", obs_tmo, 1);
    chk("lock_period", obs_period, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lfsr_period_ctrl.md
Name: lfsr_period_ctrl

Overview:
- Controller that sequences an internal Fibonacci LFSR.
- On a start request it loads a seed, steps the LFSR once per cycle and counts the steps until the state returns to the seed.
- It reports the measured period, a maximal-length flag, a lock-up timeout and a zero-seed error.
- It is the hardware counterpart of the LFSR maximal-length bench: self-checking period measurement on chip.

Parameters:
- WIDTH, 8, LFSR width in bits; valid range 2..16.
- TAPS, 8'hB8, feedback tap mask; bit i set means state bit i is XORed into the feedback.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request a measurement; sampled only in IDLE.
- seed  in  WIDTH  starting state; sampled with start.
- busy  out  1  high in LOAD and RUN.
- done  out  1  single-cycle pulse when a result is valid.
- period  out  WIDTH  measured period; 0 on timeout or seed error.
- maximal  out  1  period == 2^WIDTH-1.
- timeout  out  1  no return to seed within 2^WIDTH steps.
- seed_err  out  1  start with seed == 0.
- lfsr_q  out  WIDTH  current LFSR state.

Behaviour:
- Reset: while reset is low, all outputs, the LFSR state, the counter and the seed register are 0, and the FSM is in IDLE. A reset asserted mid-RUN aborts the measurement with no done pulse.
- LFSR step: next = {q[WIDTH-2:0], ^(q & TAPS)}.
- Counter: WIDTH+1 bits so it can reach 2^WIDTH.
- IDLE:
  - start && seed != 0 → LOAD; seed_r <= seed; clear period, maximal, timeout and seed_err.
  - start && seed == 0 → DONE; seed_err <= 1; period <= 0.
  - start low → stay in IDLE.
- LOAD: q <= seed_r; cnt <= 0 → RUN.
- RUN, each cycle: q <= next; cnt <= cnt+1.
  - If next == seed_r: period <= cnt+1; maximal <= (cnt+1 == 2^WIDTH-1) → DONE.
  - Else if cnt+1 == 2^WIDTH: timeout <= 1; period <= 0 → DONE.
  - A match takes priority over timeout on the same cycle.
- DONE: done = 1 for exactly one cycle → IDLE. period, maximal, timeout and seed_err hold until the next accepted start.
- Latency: with the edge that samples start numbered 0, the period-P result has done high after edge P+1. For WIDTH=8, P=255, that is edge 256.
- start while busy or in DONE is ignored; no queueing.
- lfsr_q holds its last value in DONE and IDLE.
- A valid result always has exactly one of the following true: period != 0, timeout, or seed_err.

Optional Feature:
- Macro: LFSR_ZERO_DETECT_EN.
- Defined: in RUN, if next == 0 the FSM goes to DONE immediately with timeout <= 1 and period <= 0, without waiting for 2^WIDTH steps.
- Undefined: lock-up is caught only by the 2^WIDTH step timeout.
- All other behaviour is identical in both builds.

Decomposition:
- Package lfsr_pkg holds:
  - the FSM state enum: IDLE, LOAD, RUN, DONE.
  - constant DEFAULT_TAPS_8 = 8'hB8.
  - a next-state function lfsr_next(q, taps) shared with the sub-module.
- Sub-module lfsr_core (clk, reset, load, en, seed, q) holds the LFSR register. load has priority over en.
- The controller holds the FSM, the counter, the seed register and the result registers.

Test Plan:
- WIDTH=8, TAPS=8'hB8, seed 8'h32, pulse start → done after edge 256; period=255, maximal=1, timeout=0.
- WIDTH=4, TAPS=4'hC, seed 4'h1 → period=15, maximal=1, done after edge 16.
- WIDTH=4, TAPS=4'hA, seed 4'h1 → sequence 1,2,5,A,4,8,1; period=6, maximal=0.
- WIDTH=4, TAPS=4'h1, seed 4'h2 → lock-up at 0.
  - Without the macro: timeout=1 after 16 RUN steps.
  - With LFSR_ZERO_DETECT_EN: timeout=1 after 3 RUN steps.
  - period=0 in both builds.
- seed 0 with start → done on the next cycle with seed_err=1, period=0, busy never high. A start pulse mid-RUN is ignored and does not change the result.
- Assert reset low at RUN step 100 → all outputs 0 with no done pulse. Release reset, start again with seed 8'h32 → normal period=255 result.
